rs232_avm_responder: RTL and testbench

Avalon-MM slave modelling the RS-232 UART register map that the RSA wrapper polls: RX data at offset 0, TX data at offset 4, status at offset 8. Bytes enter through an inbound stream port into an RX FIFO and leave through a TX FIFO to an outbound stream port. Every access is stretched by a programmable `avm_waitrequest` delay. It serves as the bench-side and on-chip responder for the wrapper's byte protocol: 32-byte n, 32-byte d, 32-byte ciphertext in; 32-byte plaintext out.

---
 rtl/rs232_avm_responder.sv | 190 +++++++++++++++++++
 tb/tb_rs232_avm_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rs232_avm_responder.sv
// rs232_avm_responder: Avalon-MM slave exposing an RS-232 style register map
// (RX data @0, TX data @4, STATUS @8) with RX/TX byte FIFOs and a
// programmable waitrequest stretch on every access.
// Optional build: RS232_RESPONDER_LOOPBACK_EN routes TX FIFO output into RX FIFO.
module rs232_avm_responder #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        avm_clk,
    input  logic        avm_rst,
    input  logic [4:0]  avm_address,
    input  logic        avm_read,
    output logic [31:0] avm_readdata,
    input  logic        avm_write,
    input  logic [31:0] avm_writedata,
    output logic        avm_waitrequest,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic        rx_byte_ready,
    output logic [7:0]  tx_byte,
    output logic        tx_byte_valid,
    input  logic        tx_byte_ready
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = 4;
    localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
    localparam logic [4:0]    ADDR_RX     = 5'd0;
    localparam logic [4:0]    ADDR_TX     = 5'd4;
    localparam logic [4:0]    ADDR_STATUS = 5'd8;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   cnt_q, cnt_d;
    logic [4:0]      addr_q, addr_d;
    logic            rd_q, rd_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            toe_q, toe_d;
    logic [31:0]     readdata_d;

    logic [7:0]      rx_mem [FIFO_DEPTH];
    logic [AW-1:0]   rx_wr_q, rx_rd_q, rx_wr_d, rx_rd_d;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [7:0]      tx_mem [FIFO_DEPTH];
    logic [AW-1:0]   tx_wr_q, tx_rd_q, tx_wr_d, tx_rd_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

    logic            ack_c, rx_pop_c, rx_push_c, tx_push_c, tx_pop_c, tx_wr_c, toe_clr_c;
    logic [7:0]      rx_push_data_c, rx_head_d, tx_head_d;

    logic            unused_wdata;
    assign unused_wdata = ^avm_writedata[31:8];

    // Side effects happen only while the ACK cycle is on the bus
    assign ack_c     = (state_q == ST_ACK);
    assign rx_pop_c  = ack_c && rd_q && (addr_q == ADDR_RX) && (rx_cnt_q != '0);
    assign tx_wr_c   = ack_c && !rd_q && (addr_q == ADDR_TX);
    assign tx_push_c = tx_wr_c && (tx_cnt_q != DEPTH_C);
    assign toe_clr_c = ack_c && !rd_q && (addr_q == ADDR_STATUS);

`ifdef RS232_RESPONDER_LOOPBACK_EN
    logic unused_stream;
    assign unused_stream  = ^{rx_byte, rx_byte_valid, tx_byte_ready};
    assign rx_push_c      = (tx_cnt_q != '0) && (rx_cnt_q != DEPTH_C);
    assign rx_push_data_c = tx_mem[tx_rd_q];
    assign tx_pop_c       = rx_push_c;
`else
    assign rx_push_c      = rx_byte_valid && rx_byte_ready;
    assign rx_push_data_c = rx_byte;
    assign tx_pop_c       = tx_byte_valid && tx_byte_ready;
`endif

    // FIFO pointer/count next state, plus the head each FIFO will present next cycle
    always_comb begin
        rx_wr_d   = rx_wr_q + AW'(rx_push_c);
        rx_rd_d   = rx_rd_q + AW'(rx_pop_c);
        rx_cnt_d  = rx_cnt_q + CW'(rx_push_c) - CW'(rx_pop_c);
        tx_wr_d   = tx_wr_q + AW'(tx_push_c);
        tx_rd_d   = tx_rd_q + AW'(tx_pop_c);
        tx_cnt_d  = tx_cnt_q + CW'(tx_push_c) - CW'(tx_pop_c);
        rx_head_d = (rx_push_c && (rx_wr_q == rx_rd_d)) ? rx_push_data_c : rx_mem[rx_rd_d];
        tx_head_d = (tx_push_c && (tx_wr_q == tx_rd_d)) ? wdata_q : tx_mem[tx_rd_d];
        toe_d     = toe_q;
        if (tx_wr_c && (tx_cnt_q == DEPTH_C)) begin
            toe_d = 1'b1;
        end else if (toe_clr_c) begin
            toe_d = 1'b0;
        end
    end

    // Access FSM next state; readdata is captured from the FIFO state that the ACK cycle will see
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        readdata_d = avm_readdata;
        case (state_q)
            ST_IDLE: begin
                if (avm_read || avm_write) begin
                    addr_d  = avm_address;
                    rd_d    = avm_read;
                    wdata_d = avm_writedata[7:0];
                    cnt_d   = WW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!avm_read && !avm_write) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WW'(1);
                    if (cnt_d == '0) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if ((state_d == ST_ACK) && rd_d) begin
            case (addr_d)
                ADDR_RX:     readdata_d = (rx_cnt_d != '0) ? {24'h0, rx_head_d} : 32'h0;
                ADDR_STATUS: readdata_d = {24'h0, (rx_cnt_d != '0), (tx_cnt_d != DEPTH_C),
                                           1'b0, toe_d, 4'h0};
                default:     readdata_d = 32'h0;
            endcase
        end
    end

    // State, control and registered outputs
    always_ff @(posedge avm_clk) begin
        if (avm_rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            addr_q          <= '0;
            rd_q            <= 1'b0;
            wdata_q         <= '0;
            toe_q           <= 1'b0;
            rx_wr_q         <= '0;
            rx_rd_q         <= '0;
            rx_cnt_q        <= '0;
            tx_wr_q         <= '0;
            tx_rd_q         <= '0;
            tx_cnt_q        <= '0;
            avm_readdata    <= 32'h0;
            avm_waitrequest <= 1'b1;
            rx_byte_ready   <= 1'b1;
            tx_byte_valid   <= 1'b0;
            tx_byte         <= 8'h00;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            addr_q          <= addr_d;
            rd_q            <= rd_d;
            wdata_q         <= wdata_d;
            toe_q           <= toe_d;
            rx_wr_q         <= rx_wr_d;
            rx_rd_q         <= rx_rd_d;
            rx_cnt_q        <= rx_cnt_d;
            tx_wr_q         <= tx_wr_d;
            tx_rd_q         <= tx_rd_d;
            tx_cnt_q        <= tx_cnt_d;
            avm_readdata    <= readdata_d;
            avm_waitrequest <= (state_d != ST_ACK);
            tx_byte         <= (tx_cnt_d != '0) ? tx_head_d : 8'h00;
`ifdef RS232_RESPONDER_LOOPBACK_EN
            rx_byte_ready   <= 1'b0;
            tx_byte_valid   <= 1'b0;
`else
            rx_byte_ready   <= (rx_cnt_d != DEPTH_C);
            tx_byte_valid   <= (tx_cnt_d != '0);
`endif
        end
    end

    // FIFO storage; contents are only observed through the counted region
    always_ff @(posedge avm_clk) begin
        if (!avm_rst && rx_push_c) begin
            rx_mem[rx_wr_q] <= rx_push_data_c;
        end
        if (!avm_rst && tx_push_c) begin
            tx_mem[tx_wr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_rs232_avm_responder.sv
// Scoreboard bench for rs232_avm_responder: bus accesses push expected
// results, monitors compare on ACK cycles and on TX stream handshakes.
module tb_rs232_avm_responder;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned WAITS = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  avm_address = '0;
    logic        avm_read = 1'b0;
    logic        avm_write = 1'b0;
    logic [31:0] avm_writedata = '0;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [7:0]  rx_byte = '0;
    logic        rx_byte_valid = 1'b0;
    logic        rx_byte_ready;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready = 1'b0;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] tx_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    rs232_avm_responder #(.FIFO_DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .avm_clk        (clk),
        .avm_rst        (rst),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_waitrequest(avm_waitrequest),
        .rx_byte        (rx_byte),
        .rx_byte_valid  (rx_byte_valid),
        .rx_byte_ready  (rx_byte_ready),
        .tx_byte        (tx_byte),
        .tx_byte_valid  (tx_byte_valid),
        .tx_byte_ready  (tx_byte_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus ACK monitor: every ACK must match the oldest issued access
    always @(negedge clk) begin
        if (!rst && !avm_waitrequest) begin
            if (sb_q.size() == 0) begin
                check("unexpected_ack", 32'h1, 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.is_rd) check("readdata", avm_readdata, e.data);
            end
        end
    end

    // TX stream monitor: each handshake must carry the next expected byte
    always @(negedge clk) begin
        if (!rst && tx_byte_valid && tx_byte_ready) begin
            if (tx_q.size() == 0) begin
                check("unexpected_tx", 32'h1, 32'h0);
            end else begin
                logic [7:0] b;
                b = tx_q.pop_front();
                check("tx_byte", 32'(tx_byte), 32'(b));
            end
        end
    end

    task automatic bus(input logic is_rd, input logic [4:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp);
        int waits;
        bit done;
        sb_q.push_back('{is_rd, exp});
        @(posedge clk); #1;
        avm_address   = addr;
        avm_read      = is_rd;
        avm_write     = !is_rd;
        avm_writedata = wd;
        waits = 0;
        done  = 1'b0;
        while (!done && waits < 64) begin
            @(negedge clk);
            if (!avm_waitrequest) done = 1'b1;
            else waits++;
        end
        if (!done) check("ack_timeout", 32'h0, 32'h1);
        else check("ack_latency", 32'(waits), 32'(WAITS + 1));
        @(posedge clk); #1;
        avm_read  = 1'b0;
        avm_write = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] wr_bytes [5];
        wr_bytes[0] = 8'h11; wr_bytes[1] = 8'h22; wr_bytes[2] = 8'h33;
        wr_bytes[3] = 8'h44; wr_bytes[4] = 8'h55;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_waitreq",  32'(avm_waitrequest), 32'h1);
        check("rst_readdata", avm_readdata, 32'h0);
        check("rst_tx_valid", 32'(tx_byte_valid), 32'h0);
        check("rst_tx_byte",  32'(tx_byte), 32'h0);
`ifdef RS232_RESPONDER_LOOPBACK_EN
        @(posedge clk); #1 rst = 1'b0;
        bus(1'b1, 5'd8, 32'h0, 32'h40);
        for (int i = 0; i < 32; i++) begin
            bus(1'b0, 5'd4, 32'(i), 32'h0);
            bus(1'b1, 5'd0, 32'h0, 32'(i));
        end
        bus(1'b1, 5'd8, 32'h0, 32'h40);
        check("lb_rx_ready", 32'(rx_byte_ready), 32'h0);
        check("lb_tx_valid", 32'(tx_byte_valid), 32'h0);
`else
        check("rst_rx_ready", 32'(rx_byte_ready), 32'h1);
        @(posedge clk); #1 rst = 1'b0;

        // status after reset, then one streamed byte
        bus(1'b1, 5'd8, 32'h0, 32'h40);
        push_rx(8'hA5);
        bus(1'b1, 5'd8, 32'h0, 32'hC0);
        bus(1'b1, 5'd0, 32'h0, 32'hA5);
        bus(1'b1, 5'd8, 32'h0, 32'h40);

        // empty RX read returns 0 and must not disturb ordering
        bus(1'b1, 5'd0, 32'h0, 32'h0);
        bus(1'b1, 5'd4, 32'h0, 32'h0);
        bus(1'b1, 5'd12, 32'h0, 32'h0);
        push_rx(8'h01); push_rx(8'h02); push_rx(8'h03); push_rx(8'h04);
        @(negedge clk);
        check("rx_full_ready", 32'(rx_byte_ready), 32'h0);
        bus(1'b1, 5'd0, 32'h0, 32'h01);
        bus(1'b1, 5'd0, 32'h0, 32'h02);
        bus(1'b1, 5'd0, 32'h0, 32'h03);
        bus(1'b1, 5'd0, 32'h0, 32'h04);
        bus(1'b1, 5'd0, 32'h0, 32'h0);
        check("rx_empty_ready", 32'(rx_byte_ready), 32'h1);

        // TX overflow: fifth byte dropped and TOE latched
        tx_byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tx_q.push_back(wr_bytes[i]);
            bus(1'b0, 5'd4, {24'hFFFFFF, wr_bytes[i]}, 32'h0);
        end
        @(negedge clk);
        check("tx_full_valid", 32'(tx_byte_valid), 32'h1);
        check("tx_full_head",  32'(tx_byte), 32'h11);
        bus(1'b1, 5'd8, 32'h0, 32'h10);
        bus(1'b0, 5'd8, 32'h0, 32'h0);
        bus(1'b1, 5'd8, 32'h0, 32'h00);
        tx_byte_ready = 1'b1;
        repeat (8) @(posedge clk);
        bus(1'b1, 5'd8, 32'h0, 32'h40);
        check("tx_drained", 32'(tx_q.size()), 32'h0);

        // request dropped during WAIT: no ACK, no push
        tx_byte_ready = 1'b0;
        @(posedge clk); #1;
        avm_address = 5'd4; avm_write = 1'b1; avm_writedata = 32'h77;
        @(posedge clk); #1;
        avm_write = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("drop_tx_valid", 32'(tx_byte_valid), 32'h0);
        check("drop_waitreq",  32'(avm_waitrequest), 32'h1);

        // reset during WAIT of a TX write
        @(posedge clk); #1;
        avm_address = 5'd4; avm_write = 1'b1; avm_writedata = 32'h99;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rstw_waitreq",  32'(avm_waitrequest), 32'h1);
        check("rstw_tx_valid", 32'(tx_byte_valid), 32'h0);
        avm_write = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstw_no_push", 32'(tx_byte_valid), 32'h0);
        bus(1'b1, 5'd8, 32'h0, 32'h40);
`endif
        repeat (4) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
